// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-2 stream demultiplexer with valid/ready
// handshakes on the input and on both outputs.
//
// Each output owns a 2-entry FIFO, so a stalled consumer only blocks words
// destined for its own output. The destination is either sel_i or an
// alternating round-robin pointer. Per-output counters track delivered words.
//
// Ports:
//   clk_i, rst_i      clock (rising edge) and synchronous active-high reset
//   x_i, valid_i      input word and its valid
//   sel_i             destination when alt_en_i=0 (0 -> output 1, 1 -> output 2)
//   alt_en_i          1 = alternate destinations using the round-robin pointer
//   ready_o           the selected destination buffer has room
//   x1_o/valid1_o     output 1 head word and valid, ready1_i from consumer 1
//   x2_o/valid2_o     output 2 head word and valid, ready2_i from consumer 2
//   cnt1_o/cnt2_o     words delivered on each output, wrapping

module demux_stream #(
  parameter int Width    = 16,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Width-1:0]    x_i,
  input  logic                sel_i,
  input  logic                alt_en_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [Width-1:0]    x1_o,
  output logic                valid1_o,
  input  logic                ready1_i,
  output logic [Width-1:0]    x2_o,
  output logic                valid2_o,
  input  logic                ready2_i,
  output logic [CntWidth-1:0] cnt1_o,
  output logic [CntWidth-1:0] cnt2_o
);

  logic                         rr;
  logic                         dest;
  logic                         accept;
  logic [1:0]                   full;
  logic [1:0]                   consumer_ready;
  logic [1:0]                   out_valid;
  logic [1:0][Width-1:0]        out_data;
  logic [1:0][CntWidth-1:0]     out_cnt;

  assign dest           = alt_en_i ? rr : sel_i;
  assign consumer_ready = {ready2_i, ready1_i};

  // Ready looks only at registered occupancy of the chosen buffer, never at
  // the consumer readies, so a full buffer refuses input even while popping.
  assign ready_o = !rst_i && !full[dest];
  assign accept  = valid_i && ready_o;

  // The pointer advances only on words actually accepted in alternate mode;
  // leaving alternate mode freezes it where it was.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr <= 1'b0;
    end else if (accept && alt_en_i) begin
      rr <= !rr;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_buf
      logic [Width-1:0]    head;
      logic [Width-1:0]    tail;
      logic [1:0]          occ;
      logic [CntWidth-1:0] cnt;
      logic                push;
      logic                pop;

      assign push = accept && (dest == 1'(g));
      assign pop  = (occ != 2'd0) && consumer_ready[g];

      assign full[g]      = (occ == 2'd2);
      assign out_valid[g] = (occ != 2'd0);
      assign out_data[g]  = (occ != 2'd0) ? head : '0;
      assign out_cnt[g]   = cnt;

      // Two-register FIFO: head is always the oldest word. A simultaneous
      // push and pop can only happen at occupancy 1 (push needs room, pop
      // needs a word), so the incoming word simply replaces the head.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          head <= '0;
          tail <= '0;
          occ  <= 2'd0;
          cnt  <= '0;
        end else begin
          if (pop) begin
            cnt <= cnt + 1'b1;
          end
          case ({push, pop})
            2'b10: begin
              if (occ == 2'd0) begin
                head <= x_i;
              end else begin
                tail <= x_i;
              end
              occ <= occ + 2'd1;
            end
            2'b01: begin
              head <= tail;
              occ  <= occ - 2'd1;
            end
            2'b11: begin
              head <= x_i;
            end
            default: begin
            end
          endcase
        end
      end
    end
  endgenerate

  assign x1_o     = out_data[0];
  assign x2_o     = out_data[1];
  assign valid1_o = out_valid[0];
  assign valid2_o = out_valid[1];
  assign cnt1_o   = out_cnt[0];
  assign cnt2_o   = out_cnt[1];

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: self-checking bench for demux_stream.
// A queue-based model of the two output streams is advanced every cycle from
// the driven inputs and compared against the DUT on the falling edge. Directed
// sequences with literal expectations pin the model, followed by a long
// randomized run.

module tb_demux_stream;

  localparam int Width    = 16;
  localparam int CntWidth = 16;

  logic                clk = 1'b0;
  logic                rst_i;
  logic [Width-1:0]    x_i;
  logic                sel_i;
  logic                alt_en_i;
  logic                valid_i;
  logic                ready_o;
  logic [Width-1:0]    x1_o;
  logic                valid1_o;
  logic                ready1_i;
  logic [Width-1:0]    x2_o;
  logic                valid2_o;
  logic                ready2_i;
  logic [CntWidth-1:0] cnt1_o;
  logic [CntWidth-1:0] cnt2_o;

  int checks   = 0;
  int failures = 0;

  demux_stream #(.Width(Width), .CntWidth(CntWidth)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .x_i      (x_i),
    .sel_i    (sel_i),
    .alt_en_i (alt_en_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .x1_o     (x1_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i),
    .x2_o     (x2_o),
    .valid2_o (valid2_o),
    .ready2_i (ready2_i),
    .cnt1_o   (cnt1_o),
    .cnt2_o   (cnt2_o)
  );

  always #5 clk = ~clk;

  // Generic comparator shared by the model checker and the directed checks.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle's worth of inputs and lets combinational outputs settle.
  task automatic applyStimulus(input logic rst, input logic [Width-1:0] x,
                               input logic sel, input logic alt, input logic valid,
                               input logic r1, input logic r2);
    rst_i    = rst;
    x_i      = x;
    sel_i    = sel;
    alt_en_i = alt;
    valid_i  = valid;
    ready1_i = r1;
    ready2_i = r2;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one queue per output holding the words in the order they
  // must appear, a delivered count per output and the alternation pointer.
  logic [Width-1:0]    q1[$];
  logic [Width-1:0]    q2[$];
  logic [CntWidth-1:0] m_cnt1;
  logic [CntWidth-1:0] m_cnt2;
  logic                m_rr;
  bit                  model_ok = 0;

  // Compare process: on each falling edge check the DUT against the model's
  // view of the state after the last rising edge, then advance the model by
  // what the upcoming rising edge will do with the inputs now being driven.
  always @(negedge clk) begin
    int  dsize;
    bit  dest;
    bit  acc;
    bit  pop1;
    bit  pop2;
    dest  = alt_en_i ? m_rr : sel_i;
    dsize = dest ? q2.size() : q1.size();
    if (model_ok) begin
      checkOutput("m_valid1", 32'(valid1_o), 32'(q1.size() != 0));
      checkOutput("m_valid2", 32'(valid2_o), 32'(q2.size() != 0));
      checkOutput("m_x1", 32'(x1_o), 32'((q1.size() != 0) ? q1[0] : '0));
      checkOutput("m_x2", 32'(x2_o), 32'((q2.size() != 0) ? q2[0] : '0));
      checkOutput("m_cnt1", 32'(cnt1_o), 32'(m_cnt1));
      checkOutput("m_cnt2", 32'(cnt2_o), 32'(m_cnt2));
      checkOutput("m_ready", 32'(ready_o), 32'(!rst_i && dsize < 2));
    end
    if (rst_i) begin
      q1.delete();
      q2.delete();
      m_cnt1   = '0;
      m_cnt2   = '0;
      m_rr     = 1'b0;
      model_ok = 1;
    end else if (model_ok) begin
      acc  = valid_i && (dsize < 2);
      pop1 = (q1.size() != 0) && ready1_i;
      pop2 = (q2.size() != 0) && ready2_i;
      if (pop1) begin
        void'(q1.pop_front());
        m_cnt1 = m_cnt1 + 1'b1;
      end
      if (pop2) begin
        void'(q2.pop_front());
        m_cnt2 = m_cnt2 + 1'b1;
      end
      if (acc) begin
        if (dest) q2.push_back(x_i);
        else      q1.push_back(x_i);
        if (alt_en_i) m_rr = !m_rr;
      end
    end
  end

  initial begin
    $display("[TB] starting demux_stream bench");

    // 1. Reset, then a single word to output 1.
    applyStimulus(1, '0, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("rst_ready", 32'(ready_o), 32'd0);
    stepCycle();
    checkOutput("rst_valid1", 32'(valid1_o), 32'd0);
    checkOutput("rst_valid2", 32'(valid2_o), 32'd0);
    checkOutput("rst_cnt1", 32'(cnt1_o), 32'd0);
    applyStimulus(0, 16'h1111, 0, 0, 1, 1, 0);
    checkOutput("p1_ready", 32'(ready_o), 32'd1);
    stepCycle();
    applyStimulus(0, '0, 0, 0, 0, 1, 0);
    checkOutput("p1_valid1", 32'(valid1_o), 32'd1);
    checkOutput("p1_x1", 32'(x1_o), 32'h1111);
    checkOutput("p1_valid2", 32'(valid2_o), 32'd0);
    stepCycle();
    checkOutput("p1_cnt1", 32'(cnt1_o), 32'd1);
    checkOutput("p1_valid1_after", 32'(valid1_o), 32'd0);

    // 2. Fill output 2 while its consumer stalls, then drain.
    applyStimulus(0, 16'hA001, 1, 0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 16'hA002, 1, 0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 16'hA003, 1, 0, 1, 0, 0);
    checkOutput("p2_ready_full", 32'(ready_o), 32'd0);
    checkOutput("p2_x2_hold", 32'(x2_o), 32'hA001);
    stepCycle();
    checkOutput("p2_x2_stable", 32'(x2_o), 32'hA001);
    checkOutput("p2_valid2_stable", 32'(valid2_o), 32'd1);
    applyStimulus(0, 16'hA003, 1, 0, 1, 0, 1);
    checkOutput("p2_ready_pop_same", 32'(ready_o), 32'd0);
    stepCycle();
    checkOutput("p2_x2_second", 32'(x2_o), 32'hA002);
    checkOutput("p2_ready_room", 32'(ready_o), 32'd1);
    stepCycle();
    checkOutput("p2_x2_third", 32'(x2_o), 32'hA003);
    applyStimulus(0, '0, 1, 0, 0, 0, 1);
    stepCycle();
    checkOutput("p2_cnt2", 32'(cnt2_o), 32'd3);
    checkOutput("p2_valid2_empty", 32'(valid2_o), 32'd0);

    // 3. Output 2 full does not block output 1.
    applyStimulus(0, 16'hB001, 1, 0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 16'hB002, 1, 0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 16'h0005, 0, 0, 1, 1, 0);
    checkOutput("p3_ready_sel0", 32'(ready_o), 32'd1);
    stepCycle();
    applyStimulus(0, 16'h0006, 0, 0, 1, 1, 0);
    checkOutput("p3_x1_first", 32'(x1_o), 32'h0005);
    stepCycle();
    applyStimulus(0, '0, 0, 0, 0, 1, 0);
    checkOutput("p3_x1_second", 32'(x1_o), 32'h0006);
    checkOutput("p3_x2_held", 32'(x2_o), 32'hB001);
    stepCycle();
    checkOutput("p3_cnt1", 32'(cnt1_o), 32'd3);
    applyStimulus(0, '0, 0, 0, 0, 0, 1);
    stepCycle();
    stepCycle();
    checkOutput("p3_cnt2", 32'(cnt2_o), 32'd5);

    // 4. Alternating destinations starting from pointer 0.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 16'(16'h0010 + k), 0, 1, 1, 1, 1);
      stepCycle();
      if (k % 2 == 0) checkOutput("p4_x1_alt", 32'(x1_o), 32'(16'h0010 + k));
      else            checkOutput("p4_x2_alt", 32'(x2_o), 32'(16'h0010 + k));
    end
    applyStimulus(0, '0, 0, 1, 0, 1, 1);
    stepCycle();
    checkOutput("p4_cnt1", 32'(cnt1_o), 32'd6);
    checkOutput("p4_cnt2", 32'(cnt2_o), 32'd8);

    // 5. Push and pop together at occupancy 1.
    applyStimulus(0, 16'h0055, 0, 0, 1, 0, 0);
    stepCycle();
    checkOutput("p5_x1_old", 32'(x1_o), 32'h0055);
    applyStimulus(0, 16'h0066, 0, 0, 1, 1, 0);
    checkOutput("p5_ready", 32'(ready_o), 32'd1);
    stepCycle();
    checkOutput("p5_x1_new", 32'(x1_o), 32'h0066);
    checkOutput("p5_valid1", 32'(valid1_o), 32'd1);
    applyStimulus(0, '0, 0, 0, 0, 1, 0);
    stepCycle();
    checkOutput("p5_valid1_empty", 32'(valid1_o), 32'd0);
    checkOutput("p5_cnt1", 32'(cnt1_o), 32'd8);

    // 6. Reset with both buffers full.
    applyStimulus(0, 16'hC001, 0, 0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 16'hC002, 0, 0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 16'hC003, 1, 0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 16'hC004, 1, 0, 1, 0, 0);
    stepCycle();
    applyStimulus(0, 16'hC005, 1, 0, 1, 0, 0);
    checkOutput("p6_ready_full", 32'(ready_o), 32'd0);
    applyStimulus(1, 16'hC005, 1, 0, 1, 0, 0);
    checkOutput("p6_ready_in_rst", 32'(ready_o), 32'd0);
    stepCycle();
    checkOutput("p6_valid1", 32'(valid1_o), 32'd0);
    checkOutput("p6_valid2", 32'(valid2_o), 32'd0);
    checkOutput("p6_x1", 32'(x1_o), 32'd0);
    checkOutput("p6_x2", 32'(x2_o), 32'd0);
    checkOutput("p6_cnt1", 32'(cnt1_o), 32'd0);
    checkOutput("p6_cnt2", 32'(cnt2_o), 32'd0);
    checkOutput("p6_ready_held", 32'(ready_o), 32'd0);
    applyStimulus(0, '0, 1, 0, 0, 0, 0);
    checkOutput("p6_ready_release", 32'(ready_o), 32'd1);
    stepCycle();

    // Randomized run checked entirely by the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 149) == 0),
                    16'($urandom()),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 2) == 0));
      stepCycle();
    end

    applyStimulus(0, '0, 0, 0, 0, 1, 1);
    stepCycle();
    stepCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Registered 1-to-2 stream demultiplexer with valid/ready handshakes on the input and on both outputs.
- Steers CORDIC result words from a single producer to one of two consumers, e.g. the sine/cosine result path versus a bypass/debug path.
- Each output has a 2-entry buffer, so one stalled consumer does not immediately stall the other.
- Supports explicit selection (sel_i) and alternating round-robin steering. Counts transfers per output.

Parameters:
Width, 16, data word width in bits
CntWidth, 16, width of per-output transfer counters

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
x_i  input  Width  input data word
sel_i  input  1  destination select when alt_en_i=0 (0 -> output 1, 1 -> output 2)
alt_en_i  input  1  1 = alternate destinations, ignore sel_i
valid_i  input  1  input word valid
ready_o  output  1  block can accept the word into the selected destination
x1_o  output  Width  output 1 data (head of buffer 1)
valid1_o  output  1  output 1 valid
ready1_i  input  1  consumer 1 ready
x2_o  output  Width  output 2 data (head of buffer 2)
valid2_o  output  1  output 2 valid
ready2_i  input  1  consumer 2 ready
cnt1_o  output  CntWidth  words delivered on output 1
cnt2_o  output  CntWidth  words delivered on output 2

Behaviour:
- One clock domain, clk_i. Reset is synchronous and active-high on rst_i.
- Reset (rst_i=1 at edge):
  - Both buffers empty; valid1_o=valid2_o=0; x1_o=x2_o=0.
  - cnt1_o=cnt2_o=0; round-robin pointer rr=0.
  - ready_o=0 while rst_i=1.
  - Reset mid-transfer discards all buffered words.
- Destination dest: alt_en_i=0 -> dest=sel_i. alt_en_i=1 -> dest=rr.
- Buffers: each output has a 2-entry FIFO with occupancy occ1/occ2 in {0,1,2}.
- ready_o = !rst_i && (occ[dest] < 2).
  - Combinational from registered state and sel_i/alt_en_i only.
  - No path from ready1_i/ready2_i to ready_o. A full buffer refuses input even if it pops the same cycle.
- Accept: valid_i && ready_o at an edge.
  - Word is written to buffer[dest].
  - It is visible on x<dest>_o with valid<dest>_o=1 in the next cycle if the buffer was empty. Latency is 1 cycle.
- Pop: valid1_o && ready1_i at an edge removes the head of buffer 1. Same for output 2. Both outputs may pop in the same cycle.
- Push and pop on the same buffer in the same cycle: occupancy is unchanged, and FIFO order is preserved.
  - At occ=1, the new word becomes head on the next cycle.
- valid<n>_o = (occ<n> != 0).
- x<n>_o = head word when valid, 0 when empty. x<n>_o and valid<n>_o stay stable while valid<n>_o=1 and ready<n>_i=0.
- rr toggles only on an accepted word while alt_en_i=1. Deasserting alt_en_i freezes rr; re-enabling resumes from the frozen value.
- Changing sel_i/alt_en_i while valid_i=1 and ready_o=0 is legal. The producer observes the new ready_o.
- Counters: cnt<n>_o increments on each pop of output n and wraps modulo 2^CntWidth. There is no saturation.
- Words are never dropped or duplicated. Per-output order equals input acceptance order.

Test Plan:
1. Reset, alt_en_i=0, sel_i=0, push 0x1111 with ready1_i=1 -> valid1_o=1, x1_o=0x1111 one cycle after accept; cnt1_o=1 after pop; valid2_o stays 0.
2. sel_i=1, ready2_i=0, push 0xA001, 0xA002, 0xA003 back-to-back -> ready_o drops after 2 accepts; x2_o holds 0xA001. Raise ready2_i -> outputs 0xA001 then 0xA002, then 0xA003 is accepted; cnt2_o=3.
3. Output 2 full (ready2_i=0), switch to sel_i=0 -> ready_o=1 and words 0x0005, 0x0006 flow to output 1 unaffected.
4. alt_en_i=1, both ready, push 0x10..0x15 -> output 1 gets 0x10,0x12,0x14; output 2 gets 0x11,0x13,0x15; cnt1_o=cnt2_o=3.
5. occ1=1, push and pop on output 1 in the same cycle -> occ stays 1, next head is the new word, order preserved.
6. Assert rst_i with both buffers full -> next cycle valids 0, x outputs 0, counters 0, ready_o=0 during reset; ready_o=1 after release.
